// File: rtl/csr_excp_unit.sv
// Commit-side exception/ERTN sink: architectural CSRs, interrupt pending,
// stable timer and the registered fetch redirect.
module csr_excp_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        excp_flush,
  input  logic        ertn_flush,
  input  logic [31:0] csr_era,
  input  logic [5:0]  csr_ecode,
  input  logic [8:0]  csr_esubcode,
  input  logic        va_error,
  input  logic [31:0] bad_va,
  input  logic        excp_tlbrefill,
  input  logic        excp_tlb,
  input  logic [18:0] excp_tlb_vppn,
  input  logic        csr_we,
  input  logic [13:0] csr_waddr,
  input  logic [31:0] csr_wdata,
  input  logic [13:0] csr_raddr,
  output logic [31:0] csr_rdata,
  input  logic [7:0]  hw_int,
  output logic        has_int,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic [1:0]  crmd_plv,
  output logic        crmd_da,
  output logic        crmd_pg
);

  localparam logic [13:0] A_CRMD   = 14'h0;
  localparam logic [13:0] A_PRMD   = 14'h1;
  localparam logic [13:0] A_ECFG   = 14'h4;
  localparam logic [13:0] A_ESTAT  = 14'h5;
  localparam logic [13:0] A_ERA    = 14'h6;
  localparam logic [13:0] A_BADV   = 14'h7;
  localparam logic [13:0] A_EENTRY = 14'hC;
  localparam logic [13:0] A_TLBEHI = 14'h11;
  localparam logic [13:0] A_TCFG   = 14'h41;
  localparam logic [13:0] A_TVAL   = 14'h42;
  localparam logic [13:0] A_TICLR  = 14'h44;
  localparam logic [13:0] A_TLBREN = 14'h88;

  logic [1:0]  plv;
  logic        ie;
  logic        da;
  logic        pg;
  logic [1:0]  pplv;
  logic        pie;
  logic [12:0] lie;
  logic [8:0]  esubcode;
  logic [5:0]  ecode;
  logic [12:0] is_r;
  logic [31:0] era;
  logic [31:0] badv;
  logic [25:0] eentry;
  logic [25:0] tlbrentry;
  logic [18:0] vppn;
  logic [31:0] tcfg;
  logic [31:0] tval;

  logic        we;
  logic        tcfg_wr;
  logic        ticlr_clr;
  logic        timer_fire;

  // Software writes lose to any commit event in the same cycle
  assign we         = csr_we & ~excp_flush & ~ertn_flush;
  assign tcfg_wr    = we & (csr_waddr == A_TCFG);
  assign ticlr_clr  = we & (csr_waddr == A_TICLR) & csr_wdata[0];
  assign timer_fire = tcfg[0] & (tval == 32'd1) & ~tcfg_wr;

  always_ff @(posedge clk) begin
    if (rst) begin
      plv            <= '0;
      ie             <= 1'b0;
      da             <= 1'b1;
      pg             <= 1'b0;
      pplv           <= '0;
      pie            <= 1'b0;
      lie            <= '0;
      esubcode       <= '0;
      ecode          <= '0;
      is_r           <= '0;
      era            <= '0;
      badv           <= '0;
      eentry         <= '0;
      tlbrentry      <= '0;
      vppn           <= '0;
      tcfg           <= '0;
      tval           <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      is_r[9:2]      <= hw_int;
      redirect_valid <= excp_flush | ertn_flush;

      if (tcfg_wr)
        tval <= {csr_wdata[31:2], 2'b00};
      else if (tcfg[0]) begin
        if (tval != 32'd0)
          tval <= tval - 32'd1;
        else if (tcfg[1])
          tval <= {tcfg[31:2], 2'b00};
      end

      // A fire in the same cycle as a clear keeps the interrupt pending
      if (timer_fire)
        is_r[11] <= 1'b1;
      else if (ticlr_clr)
        is_r[11] <= 1'b0;

      if (excp_flush) begin
        pplv     <= plv;
        pie      <= ie;
        plv      <= '0;
        ie       <= 1'b0;
        era      <= csr_era;
        ecode    <= csr_ecode;
        esubcode <= csr_esubcode;
        if (va_error)
          badv <= bad_va;
        if (excp_tlb)
          vppn <= excp_tlb_vppn;
        if (excp_tlbrefill) begin
          da <= 1'b1;
          pg <= 1'b0;
        end
        redirect_pc <= excp_tlbrefill ? {tlbrentry, 6'b0}
                                      : {eentry, 6'b0};
      end else if (ertn_flush) begin
        plv <= pplv;
        ie  <= pie;
        if (ecode == 6'h3F) begin
          da <= 1'b0;
          pg <= 1'b1;
        end
        redirect_pc <= era;
      end else if (we) begin
        case (csr_waddr)
          A_CRMD: begin
            pg  <= csr_wdata[4];
            da  <= csr_wdata[3];
            ie  <= csr_wdata[2];
            plv <= csr_wdata[1:0];
          end
          A_PRMD: begin
            pie  <= csr_wdata[2];
            pplv <= csr_wdata[1:0];
          end
          A_ECFG:   lie       <= csr_wdata[12:0] & 13'h1BFF;
          A_ESTAT:  is_r[1:0] <= csr_wdata[1:0];
          A_ERA:    era       <= csr_wdata;
          A_BADV:   badv      <= csr_wdata;
          A_EENTRY: eentry    <= csr_wdata[31:6];
          A_TLBEHI: vppn      <= csr_wdata[31:13];
          A_TCFG:   tcfg      <= csr_wdata;
          A_TLBREN: tlbrentry <= csr_wdata[31:6];
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    csr_rdata = '0;
    case (csr_raddr)
      A_CRMD:   csr_rdata = {27'b0, pg, da, ie, plv};
      A_PRMD:   csr_rdata = {29'b0, pie, pplv};
      A_ECFG:   csr_rdata = {19'b0, lie};
      A_ESTAT:  csr_rdata = {1'b0, esubcode, ecode, 3'b0, is_r};
      A_ERA:    csr_rdata = era;
      A_BADV:   csr_rdata = badv;
      A_EENTRY: csr_rdata = {eentry, 6'b0};
      A_TLBEHI: csr_rdata = {vppn, 13'b0};
      A_TCFG:   csr_rdata = tcfg;
      A_TVAL:   csr_rdata = tval;
      A_TLBREN: csr_rdata = {tlbrentry, 6'b0};
      default:  csr_rdata = '0;
    endcase
  end

  assign has_int  = ie & (|(is_r & lie));
  assign crmd_plv = plv;
  assign crmd_da  = da;
  assign crmd_pg  = pg;

endmodule

// File: tb/tb_csr_excp_unit.sv
// Directed bench for csr_excp_unit; redirects checked through an
// expected-target queue, CSR state through combinational reads.
module tb_csr_excp_unit;

  logic        clk;
  logic        rst;
  logic        excp_flush;
  logic        ertn_flush;
  logic [31:0] csr_era;
  logic [5:0]  csr_ecode;
  logic [8:0]  csr_esubcode;
  logic        va_error;
  logic [31:0] bad_va;
  logic        excp_tlbrefill;
  logic        excp_tlb;
  logic [18:0] excp_tlb_vppn;
  logic        csr_we;
  logic [13:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic [13:0] csr_raddr;
  logic [31:0] csr_rdata;
  logic [7:0]  hw_int;
  logic        has_int;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [1:0]  crmd_plv;
  logic        crmd_da;
  logic        crmd_pg;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];

  csr_excp_unit dut (
    .clk(clk), .rst(rst),
    .excp_flush(excp_flush), .ertn_flush(ertn_flush),
    .csr_era(csr_era), .csr_ecode(csr_ecode),
    .csr_esubcode(csr_esubcode), .va_error(va_error),
    .bad_va(bad_va), .excp_tlbrefill(excp_tlbrefill),
    .excp_tlb(excp_tlb), .excp_tlb_vppn(excp_tlb_vppn),
    .csr_we(csr_we), .csr_waddr(csr_waddr),
    .csr_wdata(csr_wdata), .csr_raddr(csr_raddr),
    .csr_rdata(csr_rdata), .hw_int(hw_int),
    .has_int(has_int), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .crmd_plv(crmd_plv),
    .crmd_da(crmd_da), .crmd_pg(crmd_pg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp,
                     input string tag);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; sample 1ns after the edge and check the redirect
  task automatic tick();
    logic [31:0] e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({31'b0, redirect_valid}, 32'd1, "redirect_valid");
      chk(redirect_pc, e, "redirect_pc");
    end else begin
      chk({31'b0, redirect_valid}, 32'd0, "redirect_idle");
    end
  endtask

  task automatic rd(input logic [13:0] a, input logic [31:0] exp,
                    input string tag);
    csr_raddr = a;
    #1;
    chk(csr_rdata, exp, tag);
  endtask

  task automatic wr(input logic [13:0] a, input logic [31:0] d);
    csr_we    = 1'b1;
    csr_waddr = a;
    csr_wdata = d;
    tick();
    csr_we    = 1'b0;
  endtask

  task automatic excp(input logic [5:0] ec, input logic [31:0] ea,
                      input logic refill, input logic tlb,
                      input logic vaerr, input logic [31:0] bva,
                      input logic [31:0] target);
    excp_flush     = 1'b1;
    csr_ecode      = ec;
    csr_era        = ea;
    excp_tlbrefill = refill;
    excp_tlb       = tlb;
    va_error       = vaerr;
    bad_va         = bva;
    excp_tlb_vppn  = bva[31:13];
    exp_q.push_back(target);
    tick();
    excp_flush     = 1'b0;
    excp_tlbrefill = 1'b0;
    excp_tlb       = 1'b0;
    va_error       = 1'b0;
  endtask

  task automatic ertn(input logic [31:0] target);
    ertn_flush = 1'b1;
    exp_q.push_back(target);
    tick();
    ertn_flush = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    excp_flush = 0; ertn_flush = 0;
    csr_era = 0; csr_ecode = 0; csr_esubcode = 0;
    va_error = 0; bad_va = 0;
    excp_tlbrefill = 0; excp_tlb = 0; excp_tlb_vppn = 0;
    csr_we = 0; csr_waddr = 0; csr_wdata = 0; csr_raddr = 0;
    hw_int = 0;
    tick();
    tick();
    rst = 1'b0;

    rd(14'h0, 32'h8, "reset_crmd");
    chk({31'b0, crmd_da}, 32'd1, "reset_da");
    chk({30'b0, crmd_plv}, 32'd0, "reset_plv");
    chk({31'b0, has_int}, 32'd0, "reset_has_int");
    rd(14'h6, 32'h0, "reset_era");
    rd(14'h42, 32'h0, "reset_tval");

    wr(14'h4, 32'h1FFF);
    rd(14'h4, 32'h1BFF, "ecfg_bit10");
    rd(14'h3, 32'h0, "unimpl_addr");
    wr(14'h44, 32'h1);
    rd(14'h44, 32'h0, "ticlr_read");
    wr(14'h4, 32'h0);

    // Plain exception entry
    wr(14'hC, 32'h1C000040);
    wr(14'h0, 32'hF);
    chk({30'b0, crmd_plv}, 32'd3, "plv_write");
    excp(6'h0B, 32'h1C001234, 0, 0, 0, 32'h0, 32'h1C000040);
    rd(14'h0, 32'h8, "entry_crmd");
    rd(14'h1, 32'h7, "entry_prmd");
    rd(14'h6, 32'h1C001234, "entry_era");
    rd(14'h5, 32'h000B0000, "entry_estat");

    // TLB refill entry then ERTN
    wr(14'h88, 32'h80000000);
    wr(14'h0, 32'h6);
    excp(6'h3F, 32'h1C002000, 1, 1, 1, 32'h12345678, 32'h80000000);
    chk({31'b0, crmd_da}, 32'd1, "refill_da");
    chk({31'b0, crmd_pg}, 32'd0, "refill_pg");
    rd(14'h7, 32'h12345678, "refill_badv");
    rd(14'h11, 32'h12344000, "refill_tlbehi");
    rd(14'h1, 32'h6, "refill_prmd");
    ertn(32'h1C002000);
    chk({31'b0, crmd_da}, 32'd0, "ertn_da");
    chk({31'b0, crmd_pg}, 32'd1, "ertn_pg");
    rd(14'h0, 32'h16, "ertn_crmd");

    // Everything at once: only the entry takes effect
    excp_flush = 1'b1; ertn_flush = 1'b1;
    csr_ecode = 6'h01; csr_era = 32'h1C003000;
    csr_we = 1'b1; csr_waddr = 14'h6; csr_wdata = 32'hDEAD0000;
    exp_q.push_back(32'h1C000040);
    tick();
    excp_flush = 1'b0; ertn_flush = 1'b0; csr_we = 1'b0;
    rd(14'h6, 32'h1C003000, "prio_era");
    rd(14'h0, 32'h10, "prio_crmd");
    rd(14'h1, 32'h6, "prio_prmd");

    // Back-to-back entry and return
    excp(6'h02, 32'h1C004000, 0, 0, 0, 32'h0, 32'h1C000040);
    ertn(32'h1C004000);
    rd(14'h0, 32'h10, "b2b_crmd");

    // Periodic timer
    wr(14'h0, 32'h4);
    wr(14'h4, 32'h800);
    wr(14'h41, 32'hB);
    rd(14'h42, 32'h8, "tval_load");
    tick();
    rd(14'h42, 32'h7, "tval_dec");
    repeat (6) tick();
    rd(14'h42, 32'h1, "tval_one");
    chk({31'b0, has_int}, 32'd0, "timer_not_yet");
    tick();
    rd(14'h42, 32'h0, "tval_zero");
    chk({31'b0, has_int}, 32'd1, "timer_fire");
    rd(14'h5, 32'h00020800, "estat_ti");
    tick();
    rd(14'h42, 32'h8, "tval_reload");
    wr(14'h44, 32'h1);
    chk({31'b0, has_int}, 32'd0, "ticlr_clear");
    repeat (6) tick();
    rd(14'h42, 32'h1, "tval_one_2");
    wr(14'h44, 32'h1);
    chk({31'b0, has_int}, 32'd1, "fire_beats_clr");
    wr(14'h44, 32'h1);
    chk({31'b0, has_int}, 32'd0, "ticlr_clear_2");

    // One-shot timer
    wr(14'h41, 32'h5);
    rd(14'h41, 32'h5, "tcfg_read");
    rd(14'h42, 32'h4, "oneshot_load");
    repeat (4) tick();
    chk({31'b0, has_int}, 32'd1, "oneshot_fire");
    wr(14'h44, 32'h1);
    repeat (10) tick();
    chk({31'b0, has_int}, 32'd0, "oneshot_no_refire");
    rd(14'h42, 32'h0, "oneshot_hold");

    // Hardware interrupt gating
    wr(14'h41, 32'h0);
    wr(14'h4, 32'h4);
    wr(14'h0, 32'h0);
    hw_int = 8'h01;
    tick();
    tick();
    chk({31'b0, has_int}, 32'd0, "hwint_masked_ie");
    csr_raddr = 14'h5;
    #1;
    chk({19'b0, csr_rdata[12:0]}, 32'h4, "estat_is");
    wr(14'h0, 32'h4);
    chk({31'b0, has_int}, 32'd1, "hwint_enabled");

    // Reset overrides a concurrent exception
    rst = 1'b1;
    excp_flush = 1'b1;
    csr_era = 32'h1C005000;
    tick();
    excp_flush = 1'b0;
    chk({31'b0, has_int}, 32'd0, "rst_has_int");
    chk({31'b0, crmd_da}, 32'd1, "rst_da");
    chk({31'b0, crmd_pg}, 32'd0, "rst_pg");
    chk({30'b0, crmd_plv}, 32'd0, "rst_plv");
    chk(redirect_pc, 32'h0, "rst_redirect_pc");
    rd(14'h6, 32'h0, "rst_era");
    rst = 1'b0;
    tick();
    rd(14'h0, 32'h8, "post_rst_crmd");
    chk({31'b0, has_int}, 32'd0, "post_rst_has_int");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
